// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants shared by the sync generator, the display
// comparators and the game-object position logic.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef logic [COUNT_W-1:0] count_t;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to the pixel rate as a registered one-clk
// enable pulse, high while the divider sits at its last count.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             tick_reg;

  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
  end

  // Tick is decoded from the next divider value so it is high exactly while
  // div_reg == CLK_DIV-1; with CLK_DIV = 1 it stays high after the first edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      div_reg  <= div_next;
      tick_reg <= (div_next == DIV_LAST);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blanking and
// line/frame strobes, all aligned to the counter values in the same clk.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [COUNT_W-1:0] h_count,
  output logic [COUNT_W-1:0] v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_LAST     = COUNT_W'(H_TOTAL - 1);
  localparam count_t V_LAST     = COUNT_W'(V_TOTAL - 1);
  localparam count_t H_ACT_C    = COUNT_W'(H_ACTIVE);
  localparam count_t V_ACT_C    = COUNT_W'(V_ACTIVE);
  localparam count_t HS_START_C = COUNT_W'(H_ACTIVE + H_FP);
  localparam count_t HS_END_C   = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t VS_START_C = COUNT_W'(V_ACTIVE + V_FP);
  localparam count_t VS_END_C   = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic   tick;
  count_t h_reg, h_next;
  count_t v_reg, v_next;
  logic   wrap_h, wrap_v;
  logic   hsync_reg, vsync_reg, video_on_reg;
  logic   line_start_reg, frame_start_reg;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    wrap_h = 1'b0;
    wrap_v = 1'b0;
    if (tick) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        wrap_h = 1'b1;
        if (v_reg == V_LAST) begin
          v_next = '0;
          wrap_v = 1'b1;
        end else begin
          v_next = v_reg + COUNT_W'(1);
        end
      end else begin
        h_next = h_reg + COUNT_W'(1);
      end
    end
  end

  // Decoding from h_next/v_next keeps sync/blank edges on the same clk as
  // the counter change instead of one clk behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_reg           <= '0;
      v_reg           <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      video_on_reg    <= 1'b1;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      hsync_reg       <= ~in_window(h_next, HS_START_C, HS_END_C);
      vsync_reg       <= ~in_window(v_next, VS_START_C, VS_END_C);
      video_on_reg    <= (h_next < H_ACT_C) && (v_next < V_ACT_C);
      line_start_reg  <= wrap_h;
      frame_start_reg <= wrap_v;
    end
  end

  assign h_count     = h_reg;
  assign v_count     = v_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign pix_tick    = tick;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed checks of vga_sync_gen: full 640x480 timing (CLK_DIV=4) over a few
// lines, plus a shrunken CLK_DIV=1 raster small enough to run whole frames.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [9:0] d_h, d_v;
  logic       d_hsync, d_vsync, d_video_on, d_pix_tick, d_line_start, d_frame_start;
  logic [9:0] s_h, s_v;
  logic       s_hsync, s_vsync, s_video_on, s_pix_tick, s_line_start, s_frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_count     (d_h),
    .v_count     (d_v),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .video_on    (d_video_on),
    .pix_tick    (d_pix_tick),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
  );

  // Small raster: 15 pixels x 8 lines, hsync at h 10..12, vsync at v 5..6.
  vga_sync_gen #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_s (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_count     (s_h),
    .v_count     (s_v),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .pix_tick    (s_pix_tick),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!(d_h == 10'(h) && d_v == 10'(v)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(d_h == 10'(h) && d_v == 10'(v)), 1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_h"}, d_h, 0);
    check({pfx, "_v"}, d_v, 0);
    check({pfx, "_hsync"}, d_hsync, 1);
    check({pfx, "_vsync"}, d_vsync, 1);
    check({pfx, "_video_on"}, d_video_on, 1);
    check({pfx, "_pix_tick"}, d_pix_tick, 0);
    check({pfx, "_line_start"}, d_line_start, 0);
    check({pfx, "_frame_start"}, d_frame_start, 0);
    check({pfx, "_s_pix_tick"}, s_pix_tick, 0);
  endtask

  // Called at the negedge where reset_n was just released.
  task automatic startup(input string pfx);
    step(1);
    check({pfx, "_c1_pix_tick"}, d_pix_tick, 0);
    check({pfx, "_c1_s_pix_tick"}, s_pix_tick, 1);
    check({pfx, "_c1_s_h"}, s_h, 0);
    step(1);
    check({pfx, "_c2_pix_tick"}, d_pix_tick, 0);
    check({pfx, "_c2_s_h"}, s_h, 1);
    step(1);
    check({pfx, "_c3_pix_tick"}, d_pix_tick, 1);
    check({pfx, "_c3_h"}, d_h, 0);
    check({pfx, "_c3_line_start"}, d_line_start, 0);
    step(1);
    check({pfx, "_c4_h"}, d_h, 1);
    check({pfx, "_c4_pix_tick"}, d_pix_tick, 0);
    check({pfx, "_c4_strobes"}, {d_line_start, d_frame_start}, 0);
  endtask

  initial begin
    int n, cnt, ls, vo, fs_no_ls, ph, pv, low_tick, hs_low, vs_low;

    // Scenario 1: reset held, then released
    step(3);
    check_reset_values("rst");
    reset_n = 1'b1;
    startup("rel");

    // Scenario 2: one line of horizontal timing
    run_to(639, 0, 4000, "reach_639");
    check("h639_video_on", d_video_on, 1);
    run_to(640, 0, 10, "reach_640");
    check("h640_video_on", d_video_on, 0);
    run_to(655, 0, 100, "reach_655");
    check("h655_hsync", d_hsync, 1);
    run_to(656, 0, 10, "reach_656");
    check("h656_hsync", d_hsync, 0);
    cnt = 0;
    n = 0;
    while (d_h != 10'd752 && n < 1000) begin
      if (!d_hsync) cnt++;
      step(1);
      n++;
    end
    check("hsync_low_clks", cnt, 384);
    check("h752_hsync", d_hsync, 1);
    run_to(799, 0, 1000, "reach_799");
    check("h799_line_start", d_line_start, 0);
    run_to(0, 1, 10, "reach_0_1");
    check("wrap_line_start", d_line_start, 1);
    check("wrap_frame_start", d_frame_start, 0);

    // Line period and strobe width, starting on the line_start clk
    n = 0; ls = 0; vo = 0;
    do begin
      if (d_line_start) ls++;
      if (d_video_on) vo++;
      step(1);
      n++;
    end while (!d_line_start && n < 5000);
    check("line_period_clks", n, 3200);
    check("line_start_width", ls, 1);
    check("video_on_clks_per_line", vo, 2560);
    check("line2_v", d_v, 2);

    // Scenario 5: asynchronous reset mid-line
    run_to(300, 2, 2000, "reach_300_2");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    step(2);
    reset_n = 1'b1;
    startup("restart");

    // Scenarios 3/4/6 on the small CLK_DIV=1 raster
    n = 0; ph = -1; pv = -1;
    while (!s_frame_start && n < 300) begin
      ph = s_h;
      pv = s_v;
      step(1);
      n++;
    end
    check("s_frame_seen", s_frame_start, 1);
    check("s_prewrap_h", ph, 14);
    check("s_prewrap_v", pv, 7);
    check("s_wrap_h", s_h, 0);
    check("s_wrap_v", s_v, 0);
    check("s_wrap_line_start", s_line_start, 1);

    n = 0; ls = 0; vo = 0; fs_no_ls = 0; low_tick = 0; hs_low = 0; vs_low = 0;
    do begin
      if (s_line_start) ls++;
      if (s_video_on) vo++;
      if (s_frame_start && !s_line_start) fs_no_ls++;
      if (!s_pix_tick) low_tick++;
      if (!s_hsync) hs_low++;
      if (!s_vsync) vs_low++;
      step(1);
      n++;
    end while (!s_frame_start && n < 300);
    check("s_frame_period", n, 120);
    check("s_line_starts", ls, 8);
    check("s_video_on_clks", vo, 32);
    check("s_fs_without_ls", fs_no_ls, 0);
    check("s_pix_tick_low", low_tick, 0);
    check("s_hsync_low_clks", hs_low, 24);
    check("s_vsync_low_clks", vs_low, 30);

    step(1);
    check("s_frame_start_width", s_frame_start, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates the VGA raster timing for the Pong display path.
- Outputs: pixel-rate counters h_count/v_count, active-low hsync/vsync, video_on, and line/frame strobes.
- h_count/v_count feed the display comparators that test whether the beam lies inside the paddle, ball and score boxes.
- The frame strobe paces game-state updates once per frame.
- Runs from the system clock and derives the pixel rate internally with a clock-enable. No second clock domain.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz → 25 MHz); legal values ≥1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync pulse width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync pulse width, lines
V_BP, 33, vertical back porch, lines

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
h_count  out  10  current pixel column, 0..H_TOTAL-1
v_count  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_on  out  1  high when (h_count,v_count) is in the visible area
pix_tick  out  1  one-clk pulse per pixel advance
line_start  out  1  one-clk pulse in the first clk where h_count becomes 0 after a wrap
frame_start  out  1  one-clk pulse in the first clk where h_count and v_count both become 0 after a wrap

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = sum of the V_* parameters (525). Both must fit in 10 bits.
- Reset (asynchronous assert, synchronous release) sets:
  - divider = 0, h_count = 0, v_count = 0
  - hsync = 1, vsync = 1, video_on = 1 (decode of 0,0)
  - pix_tick = 0, line_start = 0, frame_start = 0
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered and high for the clk in which divider == CLK_DIV-1.
  - CLK_DIV = 1 gives pix_tick constantly high after reset.
- Counter advance happens on any clk edge where pix_tick is high:
  - h_count < H_TOTAL-1: h_count+1.
  - h_count == H_TOTAL-1: h_count → 0; v_count+1, or → 0 if v_count == V_TOTAL-1.
  - Both counters otherwise hold.
- Outputs are registered and decoded from the next-state counter values, so they align with the h_count/v_count present in the same cycle (zero relative skew, glitch-free).
  - hsync = 0 iff H_ACTIVE+H_FP ≤ h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP ≤ v_count < V_ACTIVE+V_FP+V_SYNC (490..491).
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Strobes:
  - line_start and frame_start are high for exactly one clk, the first clk of the new count value.
  - Neither strobe asserts on reset release.
  - frame_start implies line_start in the same cycle.
- Latency: first pixel advance occurs CLK_DIV clks after reset release.
- Reset mid-frame: all outputs return immediately to reset values with no partial pulses; timing restarts at (0,0).
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No illegal state is reachable.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480@60 timing constants
  - derived H_TOTAL/V_TOTAL and sync start/end constants
  - 10-bit count width constant
- These constants are also used by the display comparators and the game-object position logic.
- Sub-module pixel_tick_gen (parameter CLK_DIV; ports clk, reset_n, tick) isolates the divider.

Test Plan:
1. Reset held, then released → all outputs at reset values. First pix_tick at clk 4 after release; h_count = 1 on the following clk; no line_start/frame_start.
2. Horizontal timing, run one line → video_on falls when h_count goes 639→640. hsync low for exactly h_count 656..751 (96×4 = 384 clks). h_count 799→0 with v_count +1 and a one-clk line_start.
3. Vertical timing, run one frame → video_on low for all of v_count 480..524. vsync low only for v_count 490..491 (1600 pixel ticks). Exactly 525 line_start pulses.
4. Frame wrap at (799,524) → next advance gives (0,0) with frame_start and line_start high together for one clk. Frame period = 800×525×4 = 1,680,000 clks.
5. reset_n pulsed low asynchronously mid-line at (300,200) → outputs reset within the same cycle without a clock edge. Restart from (0,0) matches scenario 1.
6. CLK_DIV = 1 build → pix_tick constantly high after release. Line period 800 clks, frame period 420,000 clks, sync positions unchanged in pixel units.
